// File: rtl/tetris_game_sequencer.sv
// Command sequencer for the tetris field engine: turns key edges and the game tick
// into one-at-a-time field commands, and keeps the score and the game-over flag.
module tetris_game_sequencer #(
  parameter int GRAVITY_DIV = 10,
  parameter int FAST_DIV    = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        tick,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_rotate,
  input  logic        key_speed,
  input  logic [2:0]  rand_in,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [2:0]  piece_sel,
  input  logic        cmd_ready,
  input  logic        resp_valid,
  input  logic        resp_blocked,
  input  logic        resp_topout,
  input  logic [2:0]  resp_lines,
  output logic [31:0] score,
  output logic        game_over,
  output logic        busy
);

  localparam int MAX_DIV = (GRAVITY_DIV > FAST_DIV) ? GRAVITY_DIV : FAST_DIV;
  localparam int CW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam logic [CW-1:0] GRAV_RELOAD = CW'(GRAVITY_DIV - 1);
  localparam logic [CW-1:0] FAST_RELOAD = CW'(FAST_DIV - 1);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SPAWN  = 3'd1;
  localparam logic [2:0] OP_LEFT   = 3'd2;
  localparam logic [2:0] OP_RIGHT  = 3'd3;
  localparam logic [2:0] OP_ROTATE = 3'd4;
  localparam logic [2:0] OP_DOWN   = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_IDLE  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  state_t        state_r;
  logic          cmd_valid_r;
  logic [2:0]    cmd_op_r;
  logic [2:0]    piece_r;
  logic [31:0]   score_r;
  logic          game_over_r;
  logic          busy_r;

  logic          left_prev_r, right_prev_r, rot_prev_r;
  logic          left_pend_r, right_pend_r, rot_pend_r, grav_pend_r;
  logic [CW-1:0] grav_cnt_r;

  logic          left_edge_s, right_edge_s, rot_edge_s, grav_fire_s;
  logic          load_valid_s, load_left_s, load_right_s, load_rot_s, load_down_s;
  logic [2:0]    load_op_s;
  logic [32:0]   score_sum_s;

  function automatic logic [31:0] line_points(input logic [2:0] lines);
    case (lines)
      3'd0:    return 32'd0;
      3'd1:    return 32'd1;
      3'd2:    return 32'd3;
      3'd3:    return 32'd5;
      default: return 32'd8;
    endcase
  endfunction

  function automatic logic [2:0] map_piece(input logic [2:0] r);
    if (r > 3'd4) return r - 3'd5;
    else          return r;
  endfunction

  // Edge detection, pending-op selection by priority and saturating score sum.
  always_comb begin
    left_edge_s  = key_left   & ~left_prev_r;
    right_edge_s = key_right  & ~right_prev_r;
    rot_edge_s   = key_rotate & ~rot_prev_r;
    grav_fire_s  = tick & (grav_cnt_r == {CW{1'b0}}) & (state_r != ST_OVER);
    load_valid_s = 1'b0;
    load_left_s  = 1'b0;
    load_right_s = 1'b0;
    load_rot_s   = 1'b0;
    load_down_s  = 1'b0;
    load_op_s    = OP_NOP;
    if (state_r == ST_IDLE) begin
      if (rot_pend_r) begin
        load_rot_s = 1'b1;
        load_op_s  = OP_ROTATE;
      end else if (left_pend_r) begin
        load_left_s = 1'b1;
        load_op_s   = OP_LEFT;
      end else if (right_pend_r) begin
        load_right_s = 1'b1;
        load_op_s    = OP_RIGHT;
      end else if (grav_pend_r) begin
        load_down_s = 1'b1;
        load_op_s   = OP_DOWN;
      end else begin
        load_op_s = OP_NOP;
      end
      load_valid_s = rot_pend_r | left_pend_r | right_pend_r | grav_pend_r;
    end else begin
      load_valid_s = 1'b0;
    end
    score_sum_s = {1'b0, score_r} + {1'b0, line_points(resp_lines)};
  end

  // Key edge registers, sticky pending flags and the gravity divider.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      left_prev_r  <= 1'b0;
      right_prev_r <= 1'b0;
      rot_prev_r   <= 1'b0;
      left_pend_r  <= 1'b0;
      right_pend_r <= 1'b0;
      rot_pend_r   <= 1'b0;
      grav_pend_r  <= 1'b0;
      grav_cnt_r   <= GRAV_RELOAD;
    end else begin
      left_prev_r  <= key_left;
      right_prev_r <= key_right;
      rot_prev_r   <= key_rotate;
      if (state_r == ST_OVER) begin
        left_pend_r  <= 1'b0;
        right_pend_r <= 1'b0;
        rot_pend_r   <= 1'b0;
        grav_pend_r  <= 1'b0;
      end else begin
        // A new edge wins over the clear of the same flag.
        left_pend_r  <= left_edge_s  | (left_pend_r  & ~load_left_s);
        right_pend_r <= right_edge_s | (right_pend_r & ~load_right_s);
        rot_pend_r   <= rot_edge_s   | (rot_pend_r   & ~load_rot_s);
        grav_pend_r  <= grav_fire_s  | (grav_pend_r  & ~load_down_s);
        if (tick) begin
          if (grav_cnt_r == {CW{1'b0}}) grav_cnt_r <= key_speed ? FAST_RELOAD : GRAV_RELOAD;
          else                          grav_cnt_r <= grav_cnt_r - CW'(1);
        end
      end
    end
  end

  // Main sequencer FSM with registered command, score and status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_SPAWN;
      cmd_valid_r <= 1'b0;
      cmd_op_r    <= OP_NOP;
      piece_r     <= 3'd0;
      score_r     <= 32'd0;
      game_over_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_SPAWN: begin
          busy_r <= 1'b1;
          if (!cmd_valid_r) begin
            piece_r     <= map_piece(rand_in);
            cmd_op_r    <= OP_SPAWN;
            cmd_valid_r <= 1'b1;
          end else if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end
        end
        ST_ISSUE, ST_CLEAR: begin
          if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            case (cmd_op_r)
              OP_SPAWN: begin
                if (resp_topout) begin
                  state_r     <= ST_OVER;
                  game_over_r <= 1'b1;
                end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end
              OP_DOWN: begin
                if (resp_blocked) begin
                  state_r     <= ST_CLEAR;
                  cmd_op_r    <= OP_CLEAR;
                  cmd_valid_r <= 1'b1;
                end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end
              OP_CLEAR: begin
                score_r <= score_sum_s[32] ? 32'hFFFF_FFFF : score_sum_s[31:0];
                state_r <= ST_SPAWN;
              end
              default: begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            endcase
          end
        end
        ST_IDLE: begin
          if (load_valid_s) begin
            cmd_op_r    <= load_op_s;
            cmd_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_OVER: begin
          cmd_valid_r <= 1'b0;
          game_over_r <= 1'b1;
          busy_r      <= 1'b1;
        end
        default: begin
          cmd_valid_r <= 1'b0;
          state_r     <= ST_SPAWN;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_op    = cmd_op_r;
  assign piece_sel = piece_r;
  assign score     = score_r;
  assign game_over = game_over_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Directed bench for tetris_game_sequencer: expected commands are queued as stimulus
// is applied and matched against each accepted cmd_valid&cmd_ready transfer.
module tb_tetris_game_sequencer;

  logic        clock = 1'b0;
  logic        resetn, tick, key_left, key_right, key_rotate, key_speed;
  logic [2:0]  rand_in;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, piece_sel;
  logic        resp_valid, resp_blocked, resp_topout;
  logic [2:0]  resp_lines;
  logic [31:0] score;
  logic        game_over, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [2:0] piece;
  } exp_t;
  exp_t sb_q[$];
  exp_t e_m;

  always #5 clock = ~clock;

  tetris_game_sequencer #(.GRAVITY_DIV(10), .FAST_DIV(1)) dut (
    .clock(clock), .resetn(resetn), .tick(tick),
    .key_left(key_left), .key_right(key_right), .key_rotate(key_rotate), .key_speed(key_speed),
    .rand_in(rand_in), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .piece_sel(piece_sel),
    .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_blocked(resp_blocked),
    .resp_topout(resp_topout), .resp_lines(resp_lines), .score(score),
    .game_over(game_over), .busy(busy)
  );

  // Scoreboard side: every accepted command must match the head of the queue.
  always @(negedge clock) begin
    if (resetn === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_xfer observed op=%0d expected no command", cmd_op);
      end
      if (sb_q.size() != 0) begin
        e_m = sb_q.pop_front();
        assert (cmd_op === e_m.op) else begin
          bad++;
          $error("FAIL xfer_op observed=%0d expected=%0d", cmd_op, e_m.op);
        end
        if (e_m.op == 3'd1) begin
          total++;
          assert (piece_sel === e_m.piece) else begin
            bad++;
            $error("FAIL xfer_piece observed=%0d expected=%0d", piece_sel, e_m.piece);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] piece);
    exp_t e;
    e.op    = op;
    e.piece = piece;
    sb_q.push_back(e);
  endtask

  task automatic wait_xfer(input string tag, input int remain);
    int n = 0;
    while (sb_q.size() > remain && n < 60) begin
      step(1);
      n++;
    end
    total++;
    assert (sb_q.size() <= remain) else begin
      bad++;
      $error("FAIL %s observed=%0d queued expected=%0d queued", tag, sb_q.size(), remain);
      while (sb_q.size() > remain) void'(sb_q.pop_front());
    end
  endtask

  task automatic respond(input logic blk, input logic top, input logic [2:0] lines);
    resp_valid   = 1'b1;
    resp_blocked = blk;
    resp_topout  = top;
    resp_lines   = lines;
    step(1);
    resp_valid   = 1'b0;
    resp_blocked = 1'b0;
    resp_topout  = 1'b0;
    resp_lines   = 3'd0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; key_left = 1'b0; key_right = 1'b0; key_rotate = 1'b0;
    key_speed = 1'b0; rand_in = 3'd3; cmd_ready = 1'b1;
    resp_valid = 1'b0; resp_blocked = 1'b0; resp_topout = 1'b0; resp_lines = 3'd0;
    step(3);
    check("rst_valid", cmd_valid, 32'd0);
    check("rst_op", cmd_op, 32'd0);
    check("rst_score", score, 32'd0);
    check("rst_over", game_over, 32'd0);
    check("rst_busy", busy, 32'd0);

    // First spawn after reset release.
    push(3'd1, 3'd3);
    resetn = 1'b1;
    step(1);
    check("spawn_valid", cmd_valid, 32'd1);
    check("spawn_op", cmd_op, 32'd1);
    wait_xfer("spawn_xfer", 0);
    check("wait_busy", busy, 32'd1);
    respond(1'b0, 1'b0, 3'd0);
    check("idle_busy", busy, 32'd0);

    // Normal gravity: nine ticks give nothing, the tenth gives one DOWN.
    repeat (9) pulse_tick();
    check("grav_nine_valid", cmd_valid, 32'd0);
    check("grav_nine_busy", busy, 32'd0);
    key_speed = 1'b1;
    push(3'd5, 3'd3);
    pulse_tick();
    wait_xfer("grav_down", 0);
    respond(1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      push(3'd5, 3'd3);
      pulse_tick();
      wait_xfer("fast_down", 0);
      respond(1'b0, 1'b0, 3'd0);
    end
    check("fast_idle", busy, 32'd0);

    // Rotate beats left; a second left edge while pending collapses.
    push(3'd4, 3'd3);
    push(3'd2, 3'd3);
    key_rotate = 1'b1;
    key_left   = 1'b1;
    step(2);
    key_left = 1'b0;
    step(1);
    key_left = 1'b1;
    wait_xfer("rotate_xfer", 1);
    respond(1'b1, 1'b0, 3'd0);
    wait_xfer("left_xfer", 0);
    respond(1'b0, 1'b0, 3'd0);
    step(5);
    check("keys_done_valid", cmd_valid, 32'd0);
    check("keys_done_busy", busy, 32'd0);
    key_left   = 1'b0;
    key_rotate = 1'b0;

    // Backpressure holds the command stable for one transfer only.
    cmd_ready = 1'b0;
    key_right = 1'b1;
    push(3'd3, 3'd3);
    step(2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", cmd_valid, 32'd1);
      check("bp_op", cmd_op, 32'd3);
      step(1);
    end
    cmd_ready = 1'b1;
    wait_xfer("bp_xfer", 0);
    step(2);
    check("bp_single", cmd_valid, 32'd0);
    respond(1'b0, 1'b0, 3'd0);
    key_right = 1'b0;

    // Lock, clear four lines, then a held spawn with remapped piece.
    push(3'd5, 3'd3);
    pulse_tick();
    wait_xfer("lock_down", 0);
    push(3'd6, 3'd3);
    respond(1'b1, 1'b0, 3'd0);
    wait_xfer("clear_xfer", 0);
    rand_in   = 3'd6;
    cmd_ready = 1'b0;
    push(3'd1, 3'd1);
    respond(1'b0, 1'b0, 3'd4);
    check("score_four", score, 32'd8);
    step(1);
    rand_in = 3'd2;
    for (int i = 0; i < 5; i++) begin
      check("spawn_hold_valid", cmd_valid, 32'd1);
      check("spawn_hold_op", cmd_op, 32'd1);
      check("spawn_hold_piece", piece_sel, 32'd1);
      step(1);
    end
    cmd_ready = 1'b1;
    wait_xfer("respawn_xfer", 0);
    respond(1'b0, 1'b0, 3'd0);

    // Second lock clearing three lines.
    push(3'd5, 3'd1);
    pulse_tick();
    wait_xfer("lock2_down", 0);
    push(3'd6, 3'd1);
    respond(1'b1, 1'b0, 3'd0);
    wait_xfer("clear2_xfer", 0);
    rand_in = 3'd7;
    push(3'd1, 3'd2);
    respond(1'b0, 1'b0, 3'd3);
    check("score_three", score, 32'd13);
    wait_xfer("respawn2_xfer", 0);
    respond(1'b0, 1'b0, 3'd0);

    // Reset while waiting on a DOWN response.
    push(3'd5, 3'd2);
    pulse_tick();
    wait_xfer("pre_rst_down", 0);
    check("pre_rst_score", score, 32'd13);
    resetn = 1'b0;
    #1;
    check("mid_rst_score", score, 32'd0);
    check("mid_rst_over", game_over, 32'd0);
    check("mid_rst_valid", cmd_valid, 32'd0);
    step(2);
    rand_in = 3'd4;
    push(3'd1, 3'd4);
    resetn = 1'b1;
    wait_xfer("post_rst_spawn", 0);

    // Top-out ends the game; keys and ticks are then ignored.
    respond(1'b0, 1'b1, 3'd0);
    check("over_flag", game_over, 32'd1);
    check("over_valid", cmd_valid, 32'd0);
    check("over_busy", busy, 32'd1);
    key_left = 1'b1;
    repeat (12) pulse_tick();
    key_left = 1'b0;
    step(3);
    check("over_hold_flag", game_over, 32'd1);
    check("over_hold_valid", cmd_valid, 32'd0);
    check("over_score", score, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
